// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the core run controller.
//   state_e    : controller sequencing states
//   port_sel_e : owner of the data_mem write port
//   mem_port_t : one data_mem port (address, write data, byte enables)
package core_ctrl_pkg;

  localparam int unsigned DIGEST_W    = 256;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned WE_W        = 4;
  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_HOST,
    SEL_CORE
  } port_sel_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [WE_W-1:0]   we;
  } mem_port_t;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Host message-word stream into the run controller.
//   valid : host word valid (host -> controller)
//   ready : controller accepts a word (controller -> host)
//   data  : 32-bit message word (host -> controller)
interface core_run_ctrl_if;
  import core_ctrl_pkg::*;

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/dmem_port_mux.sv
// Combinational data_mem port select.
//   sel       : port owner chosen by the controller FSM
//   core_port : core address / store data / byte enables
//   host_port : loader address / data / byte enables
//   core_en   : core clock enable; gates core writes so a frozen core never stores
//   mem_port  : port presented to data_mem
module dmem_port_mux
  import core_ctrl_pkg::*;
(
  input  port_sel_e sel,
  input  mem_port_t core_port,
  input  mem_port_t host_port,
  input  logic      core_en,
  output mem_port_t mem_port
);

  always_comb begin
    mem_port = '0;
    unique case (sel)
      SEL_HOST: mem_port = host_port;
      SEL_CORE: begin
        mem_port    = core_port;
        mem_port.we = core_port.we & {WE_W{core_en}};
      end
      default:  mem_port = '0;
    endcase
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Sequences one hash job on the single-cycle RV32 core: loads the message into
// data_mem with the core held in reset, runs the core until the halt instruction
// or a timeout, then freezes it and captures the digest register window.
//   clk, reset             : core clock, async active-high reset
//   start                  : job start pulse (honoured in IDLE / DONE)
//   host_wr                : host message word stream (slave side)
//   core_rst, core_en      : core reset and combinational clock enable
//   instruction            : current instruction, watched for the halt opcode
//   core_addr/din/we       : core data_mem port
//   mem_addr/din/we        : data_mem port (combinational select)
//   digest_in, digest      : live register window and captured result
//   busy, done, timeout    : job status
//   cycle_count            : RUN cycles in which the core was enabled
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned MSG_WORDS = 16,
  parameter logic [31:0] MSG_BASE  = 32'h0000_0100,
  parameter logic [31:0] HALT_INSN = EBREAK_INSN,
  parameter logic [31:0] TIMEOUT   = 32'd1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  core_run_ctrl_if.slave      host_wr,
  output logic                core_rst,
  output logic                core_en,
  input  logic [31:0]         instruction,
  input  logic [31:0]         core_addr,
  input  logic [31:0]         core_din,
  input  logic [3:0]          core_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_din,
  output logic [3:0]          mem_we,
  input  logic [DIGEST_W-1:0] digest_in,
  output logic [DIGEST_W-1:0] digest,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [31:0]         cycle_count
);

  localparam int unsigned IDX_W = $clog2(MSG_WORDS + 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    word_idx_q, word_idx_d;
  logic [31:0]         count_d, count_inc;
  logic [DIGEST_W-1:0] digest_d;
  logic                timeout_d;
  logic                ready_q;
  logic                accept;
  logic                halt_hit;
  port_sel_e           sel;
  mem_port_t           core_port, host_port, mem_port;

  assign host_wr.ready = ready_q;
  assign accept        = host_wr.valid & ready_q;
  assign halt_hit      = (instruction == HALT_INSN);
  assign count_inc     = cycle_count + 32'd1;

  // The halt instruction is never clocked into the core.
  assign core_en = (state_q == RUN) && !halt_hit;

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    count_d    = cycle_count;
    digest_d   = digest;
    timeout_d  = timeout;
    sel        = SEL_NONE;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LOAD;
          word_idx_d = '0;
          count_d    = '0;
          timeout_d  = 1'b0;
        end
      end
      LOAD: begin
        sel = SEL_HOST;
        if (accept) begin
          word_idx_d = word_idx_q + IDX_W'(1);
          if (word_idx_q == IDX_W'(MSG_WORDS - 1)) state_d = RUN;
        end
      end
      RUN: begin
        sel = SEL_CORE;
        // Halt takes priority over a coincident timeout and is not counted.
        if (halt_hit) begin
          state_d   = DONE;
          digest_d  = digest_in;
          timeout_d = 1'b0;
        end else begin
          count_d = count_inc;
          if (count_inc == TIMEOUT) begin
            state_d   = DONE;
            digest_d  = digest_in;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered status; status flags are decoded from the next state
  // so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      word_idx_q  <= '0;
      cycle_count <= '0;
      digest      <= '0;
      timeout     <= 1'b0;
      core_rst    <= 1'b1;
      ready_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      cycle_count <= count_d;
      digest      <= digest_d;
      timeout     <= timeout_d;
      core_rst    <= (state_d == IDLE) || (state_d == LOAD);
      ready_q     <= (state_d == LOAD);
      busy        <= (state_d == LOAD) || (state_d == RUN);
      done        <= (state_d == DONE);
    end
  end

  // Loader port: message word N lands at MSG_BASE + 4*N.
  always_comb begin
    host_port.addr = MSG_BASE + (32'(word_idx_q) << 2);
    host_port.din  = host_wr.data;
    host_port.we   = accept ? 4'hF : 4'h0;
    core_port.addr = core_addr;
    core_port.din  = core_din;
    core_port.we   = core_we;
  end

  dmem_port_mux u_dmem_port_mux (
    .sel       (sel),
    .core_port (core_port),
    .host_port (host_port),
    .core_en   (core_en),
    .mem_port  (mem_port)
  );

  assign mem_addr = mem_port.addr;
  assign mem_din  = mem_port.din;
  assign mem_we   = mem_port.we;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl (MSG_WORDS=16, TIMEOUT=64).
module tb_core_run_ctrl;
  import core_ctrl_pkg::*;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0010_0073;
  localparam logic [255:0] D1 = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] D2 = {8{32'h1234_5678}};
  localparam logic [255:0] D3 = {8{32'hCAFE_F00D}};

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         core_rst, core_en;
  logic [31:0]  instruction = NOP;
  logic [31:0]  core_addr = '0, core_din = '0;
  logic [3:0]   core_we = '0;
  logic [31:0]  mem_addr, mem_din;
  logic [3:0]   mem_we;
  logic [255:0] digest_in = '0;
  logic [255:0] digest;
  logic         busy, done, timeout;
  logic [31:0]  cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  int tick     = 0;

  core_run_ctrl_if host_wr ();

  core_run_ctrl #(
    .MSG_WORDS (16),
    .MSG_BASE  (32'h0000_0100),
    .HALT_INSN (32'h0010_0073),
    .TIMEOUT   (32'd64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .host_wr     (host_wr),
    .core_rst    (core_rst),
    .core_en     (core_en),
    .instruction (instruction),
    .core_addr   (core_addr),
    .core_din    (core_din),
    .core_we     (core_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_we      (mem_we),
    .digest_in   (digest_in),
    .digest      (digest),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Job-level model: phase 0=idle 1=loading 2=running 3=finished.
  int           m_phase = 0;
  int           m_words = 0;
  int           m_cycles = 0;
  logic         m_timeout = 1'b0;
  logic [255:0] m_digest = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_words = 0; m_cycles = 0; m_timeout = 1'b0; m_digest = '0;
    end else begin
      case (m_phase)
        0, 3: if (start) begin
          m_phase = 1; m_words = 0; m_cycles = 0; m_timeout = 1'b0;
        end
        1: if (host_wr.valid) begin
          m_words++;
          if (m_words == 16) m_phase = 2;
        end
        2: if (instruction == HALT) begin
          m_digest = digest_in; m_timeout = 1'b0; m_phase = 3;
        end else begin
          m_cycles++;
          if (m_cycles == 64) begin
            m_digest = digest_in; m_timeout = 1'b1; m_phase = 3;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  logic        e_en;
  logic [3:0]  e_we;
  logic [31:0] e_addr, e_din;

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    e_en   = (m_phase == 2) && (instruction != HALT);
    e_we   = 4'h0; e_addr = '0; e_din = '0;
    if (m_phase == 1) begin
      e_we   = host_wr.valid ? 4'hF : 4'h0;
      e_addr = 32'h100 + 32'(4 * m_words);
      e_din  = host_wr.data;
    end else if (m_phase == 2) begin
      e_we   = e_en ? core_we : 4'h0;
      e_addr = core_addr;
      e_din  = core_din;
    end
    chk("core_rst", core_rst, m_phase <= 1);
    chk("ready", host_wr.ready, m_phase == 1);
    chk("busy", busy, m_phase == 1 || m_phase == 2);
    chk("done", done, m_phase == 3);
    chk("timeout", timeout, m_timeout);
    chk("cycle_count", cycle_count, 32'(m_cycles));
    chk("digest", digest, m_digest);
    chk("core_en", core_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_din", mem_din, e_din);
  end

  task automatic step();
    @(posedge clk);
    #1;
    tick++;
    start         = 1'b0;
    host_wr.valid = 1'b0;
    host_wr.data  = $urandom;
    instruction   = NOP;
    core_addr     = $urandom;
    core_din      = $urandom;
    core_we       = 4'($urandom);
    digest_in     = {8{32'(tick)}};
  endtask

  // Loads n words 0xA0.. with a one-cycle valid gap every third cycle.
  task automatic load(input int n);
    int i = 0;
    int g = 0;
    while (i < n) begin
      step();
      g++;
      if (g % 3 == 0) continue;
      host_wr.valid = 1'b1;
      host_wr.data  = 32'hA0 + 32'(i);
      #3;
      chk("load_addr", mem_addr, 32'h100 + 32'(4 * i));
      chk("load_din", mem_din, 32'hA0 + 32'(i));
      chk("load_we", mem_we, 4'hF);
      chk("load_busy", busy, 1'b1);
      i++;
    end
  endtask

  task automatic run_job(input int n_run, input logic halt_last, input logic [255:0] lit,
                         input int start_at);
    for (int c = 1; c <= n_run; c++) begin
      step();
      if (c == start_at) start = 1'b1;
      if (c == n_run) begin
        digest_in = lit;
        core_we   = 4'hF;
        if (halt_last) instruction = HALT;
      end
      if (c == 1) begin
        #3;
        chk("run_core_rst", core_rst, 1'b0);
        chk("run_ready", host_wr.ready, 1'b0);
      end
      if (c == n_run && halt_last) begin
        #3;
        chk("halt_core_en", core_en, 1'b0);
        chk("halt_mem_we", mem_we, 4'h0);
      end
    end
  endtask

  task automatic finish_job(input logic exp_to, input logic [31:0] exp_cnt,
                            input logic [255:0] lit);
    step();
    #3;
    chk("job_done", done, 1'b1);
    chk("job_timeout", timeout, exp_to);
    chk("job_count", cycle_count, exp_cnt);
    chk("job_digest", digest, lit);
    chk("model_count", 32'(m_cycles), exp_cnt);
  endtask

  initial begin
    host_wr.valid = 1'b0;
    host_wr.data  = '0;
    // Reset asserted between clock edges.
    #2 reset = 1'b1;
    #1;
    chk("rst_core_rst", core_rst, 1'b1);
    chk("rst_mem_we", mem_we, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", cycle_count, 32'd0);
    chk("rst_digest", digest, 256'd0);
    step();
    step();
    reset = 1'b0;

    // Abort a load after 5 words.
    step(); start = 1'b1;
    load(5);
    step();
    #2 reset = 1'b1;
    #1;
    chk("abort_core_rst", core_rst, 1'b1);
    chk("abort_mem_we", mem_we, 4'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", host_wr.ready, 1'b0);
    step();
    reset = 1'b0;

    // Full load then halt on RUN cycle 51; start pulse mid-run is ignored.
    step(); start = 1'b1;
    load(16);
    run_job(51, 1'b1, D1, 10);
    finish_job(1'b0, 32'd50, D1);

    // Restart from DONE; stray valid is ignored.
    step(); start = 1'b1; host_wr.valid = 1'b1;
    step();
    #3;
    chk("restart_done", done, 1'b0);
    chk("restart_core_rst", core_rst, 1'b1);
    chk("restart_busy", busy, 1'b1);
    chk("restart_count", cycle_count, 32'd0);
    load(16);
    run_job(64, 1'b0, D2, 0);
    finish_job(1'b1, 32'd64, D2);

    // Halt on the cycle that would time out: halt wins.
    step(); start = 1'b1;
    load(16);
    run_job(64, 1'b1, D3, 0);
    finish_job(1'b0, 32'd63, D3);

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
